// File: rtl/krd_pkg.sv
// Shared encodings for the trigger/time-stamp datapath: exec-state codes,
// record header byte and the stamper FSM state type.
package krd_pkg;

  localparam logic [1:0] EXEC_INIT  = 2'b00;
  localparam logic [1:0] EXEC_TRG   = 2'b11;
  localparam logic [7:0] REC_HEADER = 8'hAA;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } stamp_state_e;

endpackage

// File: rtl/stamp_fifo.sv
// Synchronous record buffer with a registered occupancy count; a write
// offered while full is refused even if a read happens on the same edge.
module stamp_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/trigger_stamper.sv
// Captures start/stop times of each TRG interval and streams one record per
// completed trigger on an AXI-Stream master through a small buffer.
module trigger_stamper
  import krd_pkg::*;
#(
  parameter int unsigned TIME_STAMP_WIDTH = 16,
  parameter int unsigned CH_ID            = 0,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic [1:0]                      EXEC_STATE,
  input  logic [TIME_STAMP_WIDTH-1:0]     I_CURRENT_TIME,
  output logic [2*TIME_STAMP_WIDTH+15:0]  M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
  output logic [15:0]                     O_DROP_COUNT
);

  localparam int unsigned REC_W = 2 * TIME_STAMP_WIDTH + 16;
  localparam logic [6:0]  CH_ID_FIELD = 7'(CH_ID);

  stamp_state_e                state_q, state_d;
  logic [TIME_STAMP_WIDTH-1:0] start_q, start_d;
  logic [15:0]                 drop_cnt_q, drop_cnt_d;
  logic                        rec_wr;
  logic                        rec_wrap;
  logic [REC_W-1:0]            rec_data;
  logic [REC_W-1:0]            fifo_head;
  logic                        fifo_full;
  logic                        fifo_empty;

  // STOP is taken straight from the current time so the record lands in the
  // buffer on the very edge that sees the trigger end.
  assign rec_wrap = (I_CURRENT_TIME < start_q);
  assign rec_data = {REC_HEADER, CH_ID_FIELD, rec_wrap, start_q, I_CURRENT_TIME};

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    drop_cnt_d = drop_cnt_q;
    rec_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EXEC_STATE == EXEC_TRG) begin
          state_d = ST_ARMED;
          start_d = I_CURRENT_TIME;
        end
      end
      ST_ARMED: begin
        if (EXEC_STATE == EXEC_INIT) begin
          state_d = ST_IDLE;
        end else if (EXEC_STATE != EXEC_TRG) begin
          rec_wr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rec_wr && fifo_full && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  stamp_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (AXIS_ACLK),
    .rst_n   (AXIS_ARESETN),
    .wr_en   (rec_wr),
    .wr_data (rec_data),
    .rd_en   (M_AXIS_TREADY),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Stale buffer contents are masked so TDATA reads zero whenever nothing is offered.
  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TDATA  = fifo_empty ? '0 : fifo_head;
  assign O_DROP_COUNT  = drop_cnt_q;

endmodule

// File: tb/tb_trigger_stamper.sv
// Self-checking bench for trigger_stamper: table-driven triggers plus
// hand-written backpressure, abort and reset sequences, scoreboard-checked.
module tb_trigger_stamper;

  localparam logic [6:0] TB_CH = 7'h35;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  exec_state;
  logic [15:0] cur_time;
  logic [47:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [15:0] drop_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        mon_en   = 1'b0;
  logic [47:0] exp_q [$];

  typedef struct {
    logic [15:0] t_start;
    logic [15:0] t_stop;
    int unsigned len;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  trigger_stamper #(
    .TIME_STAMP_WIDTH (16),
    .CH_ID            (32'h35),
    .FIFO_DEPTH       (4)
  ) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .EXEC_STATE     (exec_state),
    .I_CURRENT_TIME (cur_time),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TREADY  (tready),
    .O_DROP_COUNT   (drop_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [47:0] rec(input logic [15:0] s, input logic [15:0] p, input logic w);
    return {8'hAA, TB_CH, w, s, p};
  endfunction

  // Scoreboard monitor: TVALID must track the queue, head must match while offered.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("tvalid", {63'd0, tvalid}, {63'd0, exp_q.size() != 0});
      if (tvalid && exp_q.size() != 0) begin
        check("tdata", {16'd0, tdata}, {16'd0, exp_q[0]});
        if (tready) void'(exp_q.pop_front());
      end
    end
  end

  // Entered and left at posedge+1. A new trigger may follow immediately.
  task automatic do_trigger(input logic [15:0] t_start, input logic [15:0] t_stop,
                            input int unsigned len, input logic exp_wrap,
                            input logic stored, input logic ready_at_end);
    exec_state = 2'b11;
    cur_time   = t_start;
    @(posedge clk); #1;
    for (int unsigned i = 1; i < len; i++) begin
      cur_time = 16'(t_start + i);
      @(posedge clk); #1;
    end
    exec_state = 2'b01;
    cur_time   = t_stop;
    if (ready_at_end) tready = 1'b1;
    @(posedge clk); #1;
    if (stored) exp_q.push_back(rec(t_start, t_stop, exp_wrap));
  endtask

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{t_start: 16'h0010, t_stop: 16'h0025, len: 3, exp_wrap: 1'b0};
    vecs[1] = '{t_start: 16'hFFF0, t_stop: 16'h0005, len: 5, exp_wrap: 1'b1};
    vecs[2] = '{t_start: 16'h1234, t_stop: 16'h1234, len: 1, exp_wrap: 1'b0};
    vecs[3] = '{t_start: 16'hFFFF, t_stop: 16'h0000, len: 1, exp_wrap: 1'b1};
    vecs[4] = '{t_start: 16'h0000, t_stop: 16'hFFFF, len: 2, exp_wrap: 1'b0};
    vecs[5] = '{t_start: 16'h8000, t_stop: 16'h7FFF, len: 4, exp_wrap: 1'b1};

    rst_n      = 1'b1;
    exec_state = 2'b01;
    cur_time   = 16'h0000;
    tready     = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_tvalid", {63'd0, tvalid}, 64'd0);
    check("reset_tdata", {16'd0, tdata}, 64'd0);
    check("reset_drop", {48'd0, drop_count}, 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle_cycles(2);

    // Table run with TREADY high, triggers back to back.
    for (int unsigned v = 0; v < 6; v++) begin
      do_trigger(vecs[v].t_start, vecs[v].t_stop, vecs[v].len, vecs[v].exp_wrap, 1'b1, 1'b0);
    end
    wait_drain(10);
    check("drop_after_table", {48'd0, drop_count}, 64'd0);

    // Backpressure: six triggers into a four-deep buffer.
    tready = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      do_trigger(16'(16'h2000 + k * 16'h10), 16'(16'h2005 + k * 16'h10), 2, 1'b0, k < 4, 1'b0);
    end
    idle_cycles(3);
    check("bp_drop", {48'd0, drop_count}, 64'd2);
    check("bp_valid", {63'd0, tvalid}, 64'd1);
    tready = 1'b1;
    wait_drain(20);

    // Full buffer with a pop on the same edge as the write: still dropped.
    tready = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      do_trigger(16'(16'h3000 + k * 16'h10), 16'(16'h3003 + k * 16'h10), 1, 1'b0, 1'b1, 1'b0);
    end
    do_trigger(16'h3100, 16'h3108, 1, 1'b0, 1'b0, 1'b1);
    wait_drain(20);
    check("full_pop_drop", {48'd0, drop_count}, 64'd3);

    // Write and pop coinciding while not full: both happen.
    tready = 1'b0;
    do_trigger(16'h4000, 16'h4001, 1, 1'b0, 1'b1, 1'b0);
    do_trigger(16'h4010, 16'h4012, 1, 1'b0, 1'b1, 1'b0);
    do_trigger(16'h4020, 16'h4023, 1, 1'b0, 1'b1, 1'b1);
    wait_drain(20);
    check("coincide_drop", {48'd0, drop_count}, 64'd3);

    // Abort: TRG then INIT, then running codes must not emit anything.
    exec_state = 2'b11;
    cur_time   = 16'h0100;
    @(posedge clk); #1;
    exec_state = 2'b00;
    @(posedge clk); #1;
    exec_state = 2'b10;
    cur_time   = 16'h0150;
    idle_cycles(4);
    check("abort_valid", {63'd0, tvalid}, 64'd0);
    check("abort_drop", {48'd0, drop_count}, 64'd3);
    exec_state = 2'b00;
    idle_cycles(3);
    do_trigger(16'h0200, 16'h0207, 2, 1'b0, 1'b1, 1'b0);
    wait_drain(10);

    // Reset mid-trigger with two records buffered.
    tready = 1'b0;
    do_trigger(16'h5000, 16'h5004, 1, 1'b0, 1'b1, 1'b0);
    do_trigger(16'h5010, 16'h5014, 1, 1'b0, 1'b1, 1'b0);
    exec_state = 2'b11;
    cur_time   = 16'h5020;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midreset_tvalid", {63'd0, tvalid}, 64'd0);
    check("midreset_tdata", {16'd0, tdata}, 64'd0);
    check("midreset_drop", {48'd0, drop_count}, 64'd0);
    exp_q.delete();
    exec_state = 2'b01;
    cur_time   = 16'h5030;
    tready     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(5);
    check("post_reset_valid", {63'd0, tvalid}, 64'd0);
    do_trigger(16'h6000, 16'h6009, 3, 1'b0, 1'b1, 1'b0);
    wait_drain(10);
    check("final_drop", {48'd0, drop_count}, 64'd0);

    idle_cycles(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_stamper.md
TRIGGER_STAMPER -- requirements
Module: trigger_stamper

Interface
REQ-001 SHALL have parameter TIME_STAMP_WIDTH, default 16, width of time inputs and stamp fields.
REQ-002 SHALL have parameter CH_ID, default 0, 7-bit channel identifier inserted in every record.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, record buffer depth (power of two, >=2).
REQ-004 SHALL have port AXIS_ACLK input 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port AXIS_ARESETN input 1: reset, asynchronous and active-low.
REQ-006 SHALL have port EXEC_STATE input 2: exec state; 2'b00 = INIT (stopped), 2'b11 = TRG (above threshold); other codes = running, not triggered.
REQ-007 SHALL have port I_CURRENT_TIME input TIME_STAMP_WIDTH: free-running time from the time counter.
REQ-008 SHALL have port M_AXIS_TDATA output 2*TIME_STAMP_WIDTH+16: record {8'hAA, CH_ID[6:0], WRAP, START, STOP}, MSB first.
REQ-009 SHALL have port M_AXIS_TVALID output 1: record valid.
REQ-010 SHALL have port M_AXIS_TREADY input 1: downstream accept.
REQ-011 SHALL have port O_DROP_COUNT output 16: number of records lost to a full FIFO.

Function
REQ-012 SHALL implement FSM states IDLE and ARMED.
REQ-013 SHALL, in IDLE, move to ARMED and latch START = I_CURRENT_TIME on the edge where EXEC_STATE is first sampled as TRG.
REQ-014 SHALL, in ARMED, on the edge where EXEC_STATE is sampled as neither TRG nor INIT, latch STOP = I_CURRENT_TIME, write the record, and return to IDLE.
REQ-015 SHALL, in ARMED, on the edge where EXEC_STATE is sampled as INIT, discard the pending record, write nothing, and return to IDLE.
REQ-016 SHALL, in IDLE, ignore EXEC_STATE = INIT.
REQ-017 SHALL set WRAP = 1 exactly when STOP < START (unsigned), i.e. the counter wrapped during the trigger.
REQ-018 SHALL, when a TRG pulse lasts one sample, write a record whose STOP is the time on the following edge.
REQ-019 SHALL write the record on the same edge that detects the end of the trigger.
REQ-020 SHALL assert M_AXIS_TVALID, in the cycle after that edge, when the FIFO was empty; latency is 1 cycle.
REQ-021 SHALL drive M_AXIS_TVALID = FIFO not-empty, with M_AXIS_TDATA = head record, held stable while TVALID & !TREADY.
REQ-022 SHALL pop one record on each edge with TVALID & TREADY.
REQ-023 SHALL, when a write is due with the FIFO full, drop that record even if a pop occurs on the same edge, and increment O_DROP_COUNT.
REQ-024 SHALL saturate O_DROP_COUNT at 16'hFFFF.
REQ-025 SHALL, when a write and a pop coincide with the FIFO not full, perform both and leave the occupancy unchanged.
REQ-026 SHALL accept a new trigger start on the edge after a record is written (IDLE re-entered).

Reset
REQ-027 SHALL, while AXIS_ARESETN = 0, immediately force: FSM = IDLE, FIFO empty, M_AXIS_TVALID = 0, M_AXIS_TDATA = 0, O_DROP_COUNT = 0, START/STOP = 0.
REQ-028 SHALL lose any pending or buffered record when reset is asserted mid-operation, and emit no partial record after release.

Structure
REQ-029 SHALL place the exec-state encodings (INIT = 2'b00, TRG = 2'b11) and the header byte 8'hAA in shared package krd_pkg, also used by the time counter.
REQ-030 SHALL place the FIFO in sub-module stamp_fifo (synchronous, async active-low reset, full/empty flags, registered count).

Verification
REQ-031 SHALL cover the basic record: EXEC_STATE 01->11 at time 0x0010, ->01 at 0x0025, TREADY = 1 -> one beat {AA, CH_ID, WRAP = 0, 0x0010, 0x0025}, TVALID 1 cycle after the end edge.
REQ-032 SHALL cover wrap-around: start at 0xFFF0, end at 0x0005 -> WRAP = 1, START = 0xFFF0, STOP = 0x0005.
REQ-033 SHALL cover backpressure: TREADY = 0, 6 triggers -> 4 records buffered, O_DROP_COUNT = 2; then TREADY = 1 -> 4 beats in order, TDATA stable while stalled.
REQ-034 SHALL cover abort: 11 -> 00 while ARMED -> no record, FSM IDLE, O_DROP_COUNT unchanged.
REQ-035 SHALL cover reset: AXIS_ARESETN low mid-trigger with 2 records buffered -> TVALID = 0 immediately, no beats after release until a new complete trigger.
